// File: rtl/sha256_msg_padder_if.sv
// Byte-stream upstream handshake plus the padded-block drive toward the sha256 core.
interface sha256_msg_padder_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_empty;
    logic       core_load;
    logic [7:0] core_msg;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output in_valid, in_data, in_last, in_empty,
        input  in_ready, core_load, core_msg, busy, done, err
    );

    modport slave (
        input  in_valid, in_data, in_last, in_empty,
        output in_ready, core_load, core_msg, busy, done, err
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// Collects a message of up to 55 bytes, pads it to one SHA-256 block, streams it
// to the core one byte per cycle and waits out the core's hash output window.
module sha256_msg_padder (
    input  logic                clk,
    input  logic                rst,
    sha256_msg_padder_if.slave  bus
);
    localparam int MAX_BYTES   = 55;
    localparam int CORE_CYCLES = 113;

    typedef enum logic [1:0] {COLLECT, LOAD, SEND, WAIT} state_t;

    state_t     state;
    logic [5:0] len;
    logic [6:0] cnt;
    logic       drop;
    logic       mid;
    logic [7:0] msg_buf [MAX_BYTES];

    logic       in_ready_r;
    logic       core_load_r;
    logic [7:0] core_msg_r;
    logic       busy_r;
    logic       done_r;
    logic       err_r;

    logic [8:0] bit_len;
    logic [7:0] next_byte;
    logic       accept;
    logic       overflow;

    assign bus.in_ready  = in_ready_r;
    assign bus.core_load = core_load_r;
    assign bus.core_msg  = core_msg_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;

    assign bit_len  = {len, 3'b000};
    assign accept   = bus.in_valid && in_ready_r;
    // Once a message has overflowed, every beat up to in_last is swallowed.
    assign overflow = drop || (!bus.in_empty && len == 6'(MAX_BYTES));

    // Padded block byte at index cnt; bit length never exceeds 440, so only bytes 62/63 carry it.
    always_comb begin
        next_byte = 8'h00;
        if (cnt < {1'b0, len})
            next_byte = msg_buf[cnt[5:0]];
        else if (cnt == {1'b0, len})
            next_byte = 8'h80;
        else if (cnt == 7'd62)
            next_byte = {7'b0, bit_len[8]};
        else if (cnt == 7'd63)
            next_byte = bit_len[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= COLLECT;
            len         <= '0;
            cnt         <= '0;
            drop        <= 1'b0;
            mid         <= 1'b0;
            in_ready_r  <= 1'b0;
            core_load_r <= 1'b0;
            core_msg_r  <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            for (int i = 0; i < MAX_BYTES; i++)
                msg_buf[i] <= '0;
        end else begin
            core_load_r <= 1'b0;
            done_r      <= 1'b0;
            case (state)
                COLLECT: begin
                    in_ready_r <= 1'b1;
                    if (accept) begin
                        if (!mid)
                            err_r <= 1'b0;
                        mid <= !bus.in_last;
                        if (overflow) begin
                            err_r <= 1'b1;
                            drop  <= !bus.in_last;
                            if (bus.in_last)
                                len <= '0;
                        end else begin
                            if (!bus.in_empty) begin
                                msg_buf[len] <= bus.in_data;
                                len          <= len + 6'd1;
                            end
                            if (bus.in_last) begin
                                state       <= LOAD;
                                core_load_r <= 1'b1;
                                busy_r      <= 1'b1;
                                in_ready_r  <= 1'b0;
                                cnt         <= '0;
                            end
                        end
                    end
                end
                LOAD: begin
                    core_msg_r <= next_byte;
                    cnt        <= cnt + 7'd1;
                    state      <= SEND;
                end
                SEND: begin
                    cnt <= cnt + 7'd1;
                    if (cnt == 7'd64) begin
                        core_msg_r <= '0;
                        state      <= WAIT;
                    end else begin
                        core_msg_r <= next_byte;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 7'd1;
                    // done lands on the last hash word; intake reopens the cycle after.
                    if (cnt == 7'(CORE_CYCLES - 1)) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        len    <= '0;
                    end else if (cnt == 7'(CORE_CYCLES)) begin
                        state      <= COLLECT;
                        in_ready_r <= 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule
